// File: rtl/acc_if.sv
`default_nettype none
// ============================================================================
//  Module   : acc_if
//  Purpose  : Bundles the upstream operand handshake, the run control inputs
//             and the downstream accumulator control/status outputs of
//             acc_controller.
//  Ports    : start, n_terms          - run request and operand count
//             in_data, in_valid,
//             in_ready                - upstream operand handshake
//             acc_in, load, transf,
//             acc_clear               - downstream accumulator controls
//             busy, done, count, ovf  - run status
//  Modports : master (run requester / operand source / status sink)
//             slave  (acc_controller)
//  Revision : 1.0 - initial release
// ============================================================================
interface acc_if;
  logic        start;
  logic [7:0]  n_terms;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] acc_in;
  logic        load;
  logic        transf;
  logic        acc_clear;
  logic        busy;
  logic        done;
  logic [7:0]  count;
  logic        ovf;

  modport master (
    output start, n_terms, in_data, in_valid,
    input  in_ready, acc_in, load, transf, acc_clear, busy, done, count, ovf
  );

  modport slave (
    input  start, n_terms, in_data, in_valid,
    output in_ready, acc_in, load, transf, acc_clear, busy, done, count, ovf
  );
endinterface
`default_nettype wire

// File: rtl/acc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : acc_controller
//  Purpose  : Sequences a summation run on an external accumulator. Each
//             operand is taken from the upstream handshake (WAIT), presented
//             with a load strobe (LOAD), then added with a transfer strobe
//             (ADD). Every output is a register (Moore machine).
//  Ports    : clk   - single clock, rising edge
//             clear - asynchronous active-low reset
//             bus   - acc_if.slave (start/n_terms, operand handshake,
//                     accumulator strobes, busy/done/count/ovf status)
//  Options  : ACC_OVF_DETECT_EN - when defined, a 17-bit shadow sum tracks
//             the accumulator and raises a sticky ovf on unsigned overflow;
//             otherwise ovf is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module acc_controller (
  input  wire logic clk,
  input  wire logic clear,
  acc_if.slave      bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_WAIT = 3'd2,
    S_LOAD = 3'd3,
    S_ADD  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  n_terms_q, n_terms_d;
  logic [7:0]  count_q, count_d;
  logic [15:0] acc_in_q, acc_in_d;

  logic        in_ready_q, in_ready_d;
  logic        load_q, load_d;
  logic        transf_q, transf_d;
  logic        acc_clear_q, acc_clear_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

`ifdef ACC_OVF_DETECT_EN
  logic [16:0] sum_q, sum_d;
  logic        ovf_q, ovf_d;
`endif

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    n_terms_d = n_terms_q;
    count_d   = count_q;
    acc_in_d  = acc_in_q;
`ifdef ACC_OVF_DETECT_EN
    sum_d     = sum_q;
    ovf_d     = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_terms_d = bus.n_terms;
          count_d   = 8'd0;
`ifdef ACC_OVF_DETECT_EN
          ovf_d     = 1'b0;
`endif
          state_d   = S_CLR;
        end
      end
      S_CLR: begin
`ifdef ACC_OVF_DETECT_EN
        sum_d   = 17'd0;
`endif
        state_d = (n_terms_q == 8'd0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (bus.in_valid && in_ready_q) begin
          acc_in_d = bus.in_data;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_ADD;
      end
      S_ADD: begin
        count_d = count_q + 8'd1;
`ifdef ACC_OVF_DETECT_EN
        // Mirror the accumulator's add; bit 16 means it wrapped.
        sum_d = sum_q + {1'b0, acc_in_q};
        if (sum_d[16]) begin
          ovf_d = 1'b1;
        end
`endif
        // Decide on the pre-increment count so the compare sees this add.
        state_d = ((count_q + 8'd1) == n_terms_q) ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered, so they line
    // up exactly with the state they describe.
    in_ready_d  = (state_d == S_WAIT);
    load_d      = (state_d == S_LOAD);
    transf_d    = (state_d == S_ADD);
    acc_clear_d = (state_d != S_CLR);
    busy_d      = (state_d == S_CLR) || (state_d == S_WAIT) ||
                  (state_d == S_LOAD) || (state_d == S_ADD);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q     <= S_IDLE;
      n_terms_q   <= 8'd0;
      count_q     <= 8'd0;
      acc_in_q    <= 16'd0;
      in_ready_q  <= 1'b0;
      load_q      <= 1'b0;
      transf_q    <= 1'b0;
      acc_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ACC_OVF_DETECT_EN
      sum_q       <= 17'd0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      n_terms_q   <= n_terms_d;
      count_q     <= count_d;
      acc_in_q    <= acc_in_d;
      in_ready_q  <= in_ready_d;
      load_q      <= load_d;
      transf_q    <= transf_d;
      acc_clear_q <= acc_clear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef ACC_OVF_DETECT_EN
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.acc_in    = acc_in_q;
  assign bus.load      = load_q;
  assign bus.transf    = transf_q;
  assign bus.acc_clear = acc_clear_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.count     = count_q;
`ifdef ACC_OVF_DETECT_EN
  assign bus.ovf       = ovf_q;
`else
  assign bus.ovf       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_acc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_controller
//  Purpose  : Self-checking bench for acc_controller. A driver issues runs
//             and pushes the expected result of each run into a scoreboard;
//             a monitor pops and compares when done pulses. The downstream
//             accumulator is modelled so the summed value can be checked.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acc_controller;

  logic clk = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  acc_if bus ();

  acc_controller dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  typedef struct {
    int          n;
    int          lat;
    logic [15:0] sum;
    logic        ovf;
    int          t0;
    int          irdy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int runs_checked = 0;

  int m_load = 0, m_transf = 0, m_irdy = 0, m_clr = 0;

  logic [15:0] op_a [16];
  int          st_a [16];

  // Downstream accumulator: operand register plus adder, cleared low-active.
  logic [15:0] acc_reg = 16'd0;
  logic [15:0] acc_op  = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!bus.acc_clear) begin
      acc_reg <= 16'd0;
    end else if (bus.load) begin
      acc_op <= bus.acc_in;
    end else if (bus.transf) begin
      acc_reg <= acc_reg + acc_op;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard consumer
  always @(negedge clk) begin
    if (!clear) begin
      m_load = 0; m_transf = 0; m_irdy = 0; m_clr = 0;
    end else begin
      check("load_transf_exclusive", {31'd0, bus.load & bus.transf}, 32'd0);
      if (bus.load)   m_load++;
      if (bus.transf) m_transf++;
      if (bus.in_ready) m_irdy++;
      if (!bus.acc_clear && bus.busy) m_clr++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("done_latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
          check("count", {24'd0, bus.count}, 32'(mon_e.n));
          check("acc_sum", {16'd0, acc_reg}, {16'd0, mon_e.sum});
          check("ovf", {31'd0, bus.ovf}, {31'd0, mon_e.ovf});
          check("load_pulses", 32'(m_load), 32'(mon_e.n));
          check("transf_pulses", 32'(m_transf), 32'(mon_e.n));
          check("in_ready_cycles", 32'(m_irdy), 32'(mon_e.irdy));
          check("acc_clear_cycles", 32'(m_clr), 32'd1);
          check("busy_at_done", {31'd0, bus.busy}, 32'd0);
        end
        m_load = 0; m_transf = 0; m_irdy = 0; m_clr = 0;
        runs_checked++;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acc_in"},    {16'd0, bus.acc_in}, 32'd0);
    check({tag, "_count"},     {24'd0, bus.count},  32'd0);
    check({tag, "_ovf"},       {31'd0, bus.ovf},    32'd0);
    check({tag, "_load"},      {31'd0, bus.load},   32'd0);
    check({tag, "_transf"},    {31'd0, bus.transf}, 32'd0);
    check({tag, "_in_ready"},  {31'd0, bus.in_ready}, 32'd0);
    check({tag, "_busy"},      {31'd0, bus.busy},   32'd0);
    check({tag, "_done"},      {31'd0, bus.done},   32'd0);
    check({tag, "_acc_clear"}, {31'd0, bus.acc_clear}, 32'd0);
  endtask

  // Issue one run; expected results come from plain arithmetic on the
  // operand list: sum mod 2^16, overflow if the true total exceeds 16 bits,
  // latency 3 cycles per operand plus 2 plus every stall cycle.
  task automatic run(input int n, input bit spur, input bit abort);
    exp_t e;
    int   total;
    int   stl;
    int   target;
    int   w;
    total = 0;
    stl   = 0;
    for (int i = 0; i < n; i++) begin
      total += int'(op_a[i]);
      stl   += st_a[i];
    end
    e.n    = n;
    e.lat  = 3 * n + 2 + stl;
    e.sum  = 16'(total);
`ifdef ACC_OVF_DETECT_EN
    e.ovf  = (total > 65535);
`else
    e.ovf  = 1'b0;
`endif
    e.t0   = cyc;
    e.irdy = n + stl;
    target = runs_checked + 1;
    sb.push_back(e);

    bus.start   = 1'b1;
    bus.n_terms = 8'(n);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.n_terms = 8'($urandom);

    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!bus.in_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (w >= 100) check("in_ready_timeout", 32'd0, 32'd1);
      repeat (st_a[i]) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = op_a[i];
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 16'($urandom);
      if (abort && i == 1) begin
        // Second operand is now in LOAD: pull reset asynchronously.
        clear = 1'b0;
        #1;
        check_reset_outputs("abort");
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        clear = 1'b1;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          check("idle_after_abort", {31'd0, bus.busy}, 32'd0);
        end
        return;
      end
      if (spur && i == 0) begin
        bus.start   = 1'b1;
        bus.n_terms = 8'($urandom);
        @(negedge clk);
        bus.start   = 1'b0;
      end
    end

    w = 0;
    while (runs_checked < target && w < e.lat + 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (runs_checked < target) begin
      check("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    @(negedge clk);
    check("count_hold", {24'd0, bus.count}, 32'(n));
  endtask

  task automatic clear_arrays();
    for (int i = 0; i < 16; i++) begin
      op_a[i] = 16'd0;
      st_a[i] = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b0;
    bus.n_terms  = 8'd0;
    bus.in_data  = 16'd0;
    bus.in_valid = 1'b0;
    clear_arrays();

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    clear = 1'b1;
    @(negedge clk);
    check("acc_clear_after_reset", {31'd0, bus.acc_clear}, 32'd1);
    @(negedge clk);

    // Basic three-operand run
    clear_arrays();
    op_a[0] = 16'd5; op_a[1] = 16'd10; op_a[2] = 16'd20;
    run(3, 1'b0, 1'b0);

    // Empty run
    clear_arrays();
    run(0, 1'b0, 1'b0);

    // Stall before the second operand
    clear_arrays();
    op_a[0] = 16'($urandom); op_a[1] = 16'($urandom); op_a[2] = 16'($urandom);
    st_a[1] = 4;
    run(3, 1'b0, 1'b0);

    // Overflow boundary
    clear_arrays();
    op_a[0] = 16'hFFFF; op_a[1] = 16'h0001;
    run(2, 1'b0, 1'b0);

    // Start pulsed while busy
    clear_arrays();
    for (int i = 0; i < 4; i++) op_a[i] = 16'($urandom);
    run(4, 1'b1, 1'b0);

    // Reset during LOAD of the second operand
    clear_arrays();
    for (int i = 0; i < 3; i++) op_a[i] = 16'($urandom);
    run(3, 1'b0, 1'b1);

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      int n;
      clear_arrays();
      n = int'($urandom_range(10, 0));
      for (int i = 0; i < n; i++) begin
        op_a[i] = 16'($urandom);
        st_a[i] = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(3, 1));
      end
      run(n, (n > 0) && ($urandom_range(3, 0) == 0), 1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
